// File: rtl/elevator_state_register_if.sv
// Signal bundle between the elevator state register and the full/half-floor controllers.
// master = controller/stimulus side, slave = state register.
interface elevator_state_register_if;
    logic       tick;
    logic [2:0] btn_up_raw;
    logic [2:0] btn_down_raw;
    logic [2:0] btn_in_raw;
    logic [1:0] pos_nxt;
    logic       open_nxt;
    logic [1:0] dir_nxt;
    logic [2:0] button_up;
    logic [2:0] button_down;
    logic [2:0] button_in;
    logic [2:0] loc;
    logic       at_full;
    logic       open_cur;
    logic [1:0] dir_cur;
    logic       fault;

    modport master (
        output tick, btn_up_raw, btn_down_raw, btn_in_raw, pos_nxt, open_nxt, dir_nxt,
        input  button_up, button_down, button_in, loc, at_full, open_cur, dir_cur, fault
    );

    modport slave (
        input  tick, btn_up_raw, btn_down_raw, btn_in_raw, pos_nxt, open_nxt, dir_nxt,
        output button_up, button_down, button_in, loc, at_full, open_cur, dir_cur, fault
    );
endinterface

// File: rtl/elevator_state_register.sv
// Sequential core of the 3-floor elevator: held requests, car location, door/direction state,
// door dwell timing and sticky fault flag. All outputs come straight from flops.
module elevator_state_register #(
    parameter int unsigned DWELL_TICKS = 4,
    parameter int unsigned CNT_W       = 3
) (
    input logic                      clk,
    input logic                      reset_n,
    elevator_state_register_if.slave bus
);

    localparam logic [CNT_W-1:0] DwellInit = CNT_W'(DWELL_TICKS - 1);
    localparam logic [2:0]       LocTop    = 3'd4;
    localparam logic [1:0]       MoveUp    = 2'b01;
    localparam logic [1:0]       MoveDown  = 2'b10;
    localparam logic [1:0]       CmdBad    = 2'b11;

    if (DWELL_TICKS < 1 || DWELL_TICKS >= (2 ** CNT_W)) begin : gen_bad_dwell_width
        $error("DWELL_TICKS must be >= 1 and fit in CNT_W bits");
    end

    typedef enum logic [0:0] {StClosedOrMoving, StDwell} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [2:0]       loc_q, loc_d;
    logic             open_q, open_d;
    logic [1:0]       dir_q, dir_d;
    logic             fault_q, fault_d;
    logic [2:0]       up_q, up_d;
    logic [2:0]       down_q, down_d;
    logic [2:0]       in_q, in_d;

    logic       at_full_q;
    logic       update_en;
    logic       cmd_illegal;
    logic       open_req_ok;
    logic [2:0] press_mask;
    logic [2:0] clear_mask;

    assign at_full_q   = ~loc_q[0];
    assign cmd_illegal = (bus.pos_nxt == CmdBad) || (bus.dir_nxt == CmdBad);
    assign update_en   = bus.tick && (state_q == StClosedOrMoving);
    assign open_req_ok = update_en && !cmd_illegal && bus.open_nxt && at_full_q;

    // ---------------------------------------------------------------------------------------
    // Dwell FSM: state register
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StClosedOrMoving;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
        end
    end

    // Dwell FSM: next state. The tick that finds the counter at zero is still a held tick;
    // the controller's command is taken again on the tick after that.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        case (state_q)
            StClosedOrMoving: begin
                if (open_req_ok) begin
                    state_d = StDwell;
                    dwell_d = DwellInit;
                end
            end
            StDwell: begin
                if (bus.tick) begin
                    if (dwell_q == '0) begin
                        state_d = StClosedOrMoving;
                    end else begin
                        dwell_d = dwell_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = StClosedOrMoving;
            end
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // Car state update (location, door, direction, fault)
    // ---------------------------------------------------------------------------------------
    always_comb begin
        loc_d   = loc_q;
        open_d  = open_q;
        dir_d   = dir_q;
        fault_d = fault_q;
        if (update_en) begin
            if (cmd_illegal) begin
                fault_d = 1'b1;
            end else begin
                dir_d = bus.dir_nxt;
                if (bus.open_nxt) begin
                    // Door can only open on a full floor; between floors it stays shut.
                    if (at_full_q) begin
                        open_d = 1'b1;
                    end else begin
                        open_d  = 1'b0;
                        fault_d = 1'b1;
                    end
                end else begin
                    open_d = 1'b0;
                    case (bus.pos_nxt)
                        MoveUp: begin
                            if (loc_q >= LocTop) begin
                                fault_d = 1'b1;
                            end else begin
                                loc_d = loc_q + 3'd1;
                            end
                        end
                        MoveDown: begin
                            if (loc_q == 3'd0) begin
                                fault_d = 1'b1;
                            end else begin
                                loc_d = loc_q - 3'd1;
                            end
                        end
                        default: begin
                            loc_d = loc_q;
                        end
                    endcase
                end
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Request latches
    // ---------------------------------------------------------------------------------------
    always_comb begin
        press_mask = 3'b111;
        clear_mask = 3'b000;
        if (open_q && at_full_q) begin
            press_mask = ~(3'b001 << loc_q[2:1]);
        end
        // Clearing uses the post-update state so the serving edge itself drops the request.
        if (bus.tick && open_d && !loc_d[0]) begin
            clear_mask = 3'b001 << loc_d[2:1];
        end
        up_d   = (up_q   | (bus.btn_up_raw   & press_mask & 3'b011)) & ~clear_mask;
        down_d = (down_q | (bus.btn_down_raw & press_mask & 3'b110)) & ~clear_mask;
        in_d   = (in_q   | (bus.btn_in_raw   & press_mask))          & ~clear_mask;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loc_q   <= '0;
            open_q  <= 1'b0;
            dir_q   <= '0;
            fault_q <= 1'b0;
            up_q    <= '0;
            down_q  <= '0;
            in_q    <= '0;
        end else begin
            loc_q   <= loc_d;
            open_q  <= open_d;
            dir_q   <= dir_d;
            fault_q <= fault_d;
            up_q    <= up_d;
            down_q  <= down_d;
            in_q    <= in_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------------------------
    assign bus.button_up   = up_q;
    assign bus.button_down = down_q;
    assign bus.button_in   = in_q;
    assign bus.loc         = loc_q;
    assign bus.at_full     = at_full_q;
    assign bus.open_cur    = open_q;
    assign bus.dir_cur     = dir_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_elevator_state_register.sv
// Scoreboard bench for elevator_state_register: directed scenarios then random stimulus,
// checked against a behavioural model of floors, door hold time and requests.
module tb_elevator_state_register;

    localparam int DWELL = 4;

    logic clk;
    logic reset_n;

    elevator_state_register_if bus ();

    elevator_state_register #(
        .DWELL_TICKS(DWELL),
        .CNT_W      (3)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] up;
        logic [2:0] dn;
        logic [2:0] cab;
        logic [2:0] loc;
        logic       at_full;
        logic       open;
        logic [1:0] dir;
        logic       fault;
    } exp_t;

    exp_t scb[$];
    int   total = 0;
    int   bad   = 0;

    // Behavioural model: car position in half-floors, door, and remaining held ticks.
    bit m_up[3];
    bit m_dn[3];
    bit m_in[3];
    int m_loc;
    int m_dir;
    int m_hold;
    bit m_open;
    bit m_fault;

    function automatic void model_reset();
        for (int f = 0; f < 3; f++) begin
            m_up[f] = 0;
            m_dn[f] = 0;
            m_in[f] = 0;
        end
        m_loc   = 0;
        m_dir   = 0;
        m_hold  = 0;
        m_open  = 0;
        m_fault = 0;
    endfunction

    function automatic void model_step(input bit t, input logic [2:0] u, input logic [2:0] d,
                                       input logic [2:0] c, input int pos, input bit o,
                                       input int dr);
        int n_loc  = m_loc;
        int n_dir  = m_dir;
        int n_hold = m_hold;
        bit n_open = m_open;
        if (t) begin
            if (m_hold > 0) begin
                n_hold = m_hold - 1;
            end else if (pos == 3 || dr == 3) begin
                m_fault = 1;
            end else begin
                n_dir = dr;
                if (o) begin
                    if (m_loc % 2 == 0) begin
                        n_open = 1;
                        n_hold = DWELL;
                    end else begin
                        n_open  = 0;
                        m_fault = 1;
                    end
                end else begin
                    n_open = 0;
                    if (pos == 1) begin
                        if (m_loc == 4) m_fault = 1;
                        else n_loc = m_loc + 1;
                    end else if (pos == 2) begin
                        if (m_loc == 0) m_fault = 1;
                        else n_loc = m_loc - 1;
                    end
                end
            end
        end
        for (int f = 0; f < 3; f++) begin
            bool_blk: begin
                bit ignore = m_open && (m_loc % 2 == 0) && (m_loc / 2 == f);
                if (!ignore) begin
                    if (u[f] && f != 2) m_up[f] = 1;
                    if (d[f] && f != 0) m_dn[f] = 1;
                    if (c[f]) m_in[f] = 1;
                end
                if (t && n_open && (n_loc % 2 == 0) && (n_loc / 2 == f)) begin
                    m_up[f] = 0;
                    m_dn[f] = 0;
                    m_in[f] = 0;
                end
            end
        end
        m_loc  = n_loc;
        m_dir  = n_dir;
        m_hold = n_hold;
        m_open = n_open;
    endfunction

    function automatic exp_t snap(input string nm);
        exp_t e;
        e.name = nm;
        for (int f = 0; f < 3; f++) begin
            e.up[f]  = m_up[f];
            e.dn[f]  = m_dn[f];
            e.cab[f] = m_in[f];
        end
        e.loc     = 3'(m_loc);
        e.at_full = (m_loc % 2 == 0);
        e.open    = m_open;
        e.dir     = 2'(m_dir);
        e.fault   = m_fault;
        return e;
    endfunction

    task automatic set_idle();
        bus.tick         = 1'b0;
        bus.btn_up_raw   = 3'b000;
        bus.btn_down_raw = 3'b000;
        bus.btn_in_raw   = 3'b000;
        bus.pos_nxt      = 2'b00;
        bus.open_nxt     = 1'b0;
        bus.dir_nxt      = 2'b00;
    endtask

    task automatic cyc(input bit t, input logic [2:0] u, input logic [2:0] d,
                       input logic [2:0] c, input logic [1:0] p, input bit o,
                       input logic [1:0] dr, input string nm);
        @(negedge clk);
        bus.tick         = t;
        bus.btn_up_raw   = u;
        bus.btn_down_raw = d;
        bus.btn_in_raw   = c;
        bus.pos_nxt      = p;
        bus.open_nxt     = o;
        bus.dir_nxt      = dr;
        model_step(t, u, d, c, int'(p), o, int'(dr));
        scb.push_back(snap(nm));
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset(input string nm);
        @(negedge clk);
        set_idle();
        model_reset();
        scb.push_back(snap(nm));
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
    endtask

    // Monitor: one pending expectation per clock edge or reset assertion.
    initial begin
        exp_t       e;
        logic [16:0] act;
        logic [16:0] want;
        forever begin
            @(posedge clk or negedge reset_n);
            #1;
            if (scb.size() > 0) begin
                e    = scb.pop_front();
                act  = {bus.button_up, bus.button_down, bus.button_in, bus.loc, bus.at_full,
                        bus.open_cur, bus.dir_cur, bus.fault};
                want = {e.up, e.dn, e.cab, e.loc, e.at_full, e.open, e.dir, e.fault};
                total++;
                if (act !== want) begin
                    bad++;
                    $display("FAIL %s: got up=%b dn=%b in=%b loc=%0d full=%b open=%b dir=%b flt=%b, want up=%b dn=%b in=%b loc=%0d full=%b open=%b dir=%b flt=%b",
                             e.name, bus.button_up, bus.button_down, bus.button_in, bus.loc,
                             bus.at_full, bus.open_cur, bus.dir_cur, bus.fault, e.up, e.dn,
                             e.cab, e.loc, e.at_full, e.open, e.dir, e.fault);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b1;
        set_idle();
        #2;
        model_reset();
        scb.push_back(snap("reset"));
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        cyc(0, 3'b000, 3'b000, 3'b100, 2'b00, 0, 2'b00, "cab latch no tick");
        for (int k = 0; k < 4; k++) cyc(1, 3'b000, 3'b000, 3'b000, 2'b01, 0, 2'b01, "climb");
        cyc(1, 3'b000, 3'b000, 3'b000, 2'b00, 1, 2'b00, "open top clears cab");
        for (int k = 0; k < DWELL; k++)
            cyc(1, 3'b000, 3'b000, 3'b100, 2'b10, 0, 2'b10, "dwell hold");
        cyc(1, 3'b000, 3'b000, 3'b000, 2'b00, 0, 2'b00, "door close");
        for (int k = 0; k < 2; k++) cyc(1, 3'b000, 3'b000, 3'b000, 2'b10, 0, 2'b10, "descend");
        cyc(1, 3'b010, 3'b010, 3'b000, 2'b00, 1, 2'b00, "open mid with press");
        cyc(0, 3'b010, 3'b000, 3'b011, 2'b00, 0, 2'b00, "press while open");
        cyc(1, 3'b000, 3'b000, 3'b000, 2'b00, 0, 2'b00, "dwell tick");
        do_reset("reset mid dwell");
        cyc(0, 3'b100, 3'b001, 3'b000, 2'b00, 0, 2'b00, "nonexistent buttons");
        cyc(1, 3'b000, 3'b000, 3'b000, 2'b10, 0, 2'b10, "saturate bottom");
        cyc(1, 3'b000, 3'b000, 3'b000, 2'b11, 0, 2'b01, "illegal pos");
        cyc(1, 3'b000, 3'b000, 3'b000, 2'b01, 0, 2'b11, "illegal dir");
        do_reset("reset clears fault");
        cyc(1, 3'b000, 3'b000, 3'b000, 2'b01, 0, 2'b01, "half step");
        cyc(1, 3'b000, 3'b000, 3'b000, 2'b00, 1, 2'b01, "open between floors");

        for (int n = 0; n < 600; n++) begin
            bit         t;
            bit         o;
            logic [1:0] p;
            logic [1:0] dr;
            logic [2:0] u;
            logic [2:0] d;
            logic [2:0] c;
            if (n % 150 == 0) do_reset("random reset");
            t  = ($urandom_range(0, 9) < 7);
            o  = ($urandom_range(0, 3) == 0);
            p  = ($urandom_range(0, 29) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            dr = ($urandom_range(0, 29) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            u  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            d  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            c  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            cyc(t, u, d, c, p, o, dr, "random");
        end

        @(negedge clk);
        set_idle();
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (scb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", scb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
